mp_add_sequencer: RTL and testbench
===================================

// Module: mp_add_sequencer
// PURPOSE
//  Multi-precision add/subtract sequencer around one shared SLICE_W-bit parallel adder.
//  Splits two TOTAL_W = SLICE_W*NUM_SLICES-bit operands into slices and feeds them through
//  the adder LSB-slice first, one slice per clock, registering the carry between slices.
//  Sits between a requesting datapath (valid/ready in) and a result consumer (valid/ready out).
// PARAMETERS
//  SLICE_W     4   width of the shared parallel adder slice
//  NUM_SLICES  4   slices per operation; TOTAL_W = SLICE_W*NUM_SLICES (16 by default)
// PORTS
//  clk          in   1        single clock, all state on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  start_valid  in   1        request present; op_a/op_b/cin/sub valid with it
//  start_ready  out  1        sequencer can accept a request
//  op_a         in   TOTAL_W  operand A
//  op_b         in   TOTAL_W  operand B
//  cin          in   1        carry-in for add (ignored when sub=1)
//  sub          in   1        1: compute A-B (B inverted, carry-in forced to 1)
//  res_valid    out  1        result held and valid
//  res_ready    in   1        consumer takes result
//  sum          out  TOTAL_W  result A+B+cin or A-B, modulo 2^TOTAL_W
//  cout         out  1        carry out of MSB slice (for sub: 1 = no borrow)
//  ovf          out  1        two's-complement signed overflow
//  busy         out  1        high in RUN
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, start_ready=1, res_valid=0, busy=0, sum=0, cout=0,
//    ovf=0, slice index=0, carry reg=0. Reset mid-RUN/DONE aborts; the result is discarded.
//  - FSM: IDLE -> RUN on start_valid&&start_ready; RUN -> DONE after last slice;
//    DONE -> IDLE on res_ready. No other transitions.
//  - start_ready = (state==IDLE), combinational from state. Requests are not queued.
//  - Accept edge: latch A, B^{TOTAL_W{sub}}, carry=sub?1:cin, idx=0; clear sum/cout/ovf.
//  - RUN, each edge: slice idx = A[idx], B'[idx], carry -> adder; write s to sum slice idx,
//    carry <= co, idx <= idx+1. At idx==NUM_SLICES-1: cout <= co, ovf computed, state DONE.
//  - Latency: res_valid rises exactly NUM_SLICES edges after the accepting edge.
//  - ovf = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]), registered with the last slice.
//  - DONE: res_valid=1; sum/cout/ovf held stable while res_ready=0 (unbounded backpressure).
//    Edge with res_ready=1 -> IDLE, res_valid=0, sum/cout/ovf keep last values.
//  - start_valid during RUN/DONE is ignored (start_ready=0); requester must hold it.
//  - res_ready outside DONE has no effect. NUM_SLICES=1 is legal (latency 1).
//  - idx width = max(1,$clog2(NUM_SLICES)); never wraps past NUM_SLICES-1.
// STRUCTURE
//  - Shared package: state enum localparams (IDLE/RUN/DONE), TOTAL_W and idx width.
//  - One sub-module add_slice (SLICE_W params; a,b,ci -> s,co), purely combinational
//    ripple adder matching the team's existing parallel adder port set; instantiated once.
//  - Top holds FSM, operand/result registers, slice mux and carry register.
// TESTING
//  - 0x0002+0x0001, cin=0, sub=0 -> sum=0x0003, cout=0, ovf=0, res_valid 4 edges after accept.
//  - 0x00FF+0x0001 -> sum=0x0100, cout=0 (carry crosses slices 0->1->2).
//  - 0xFFFF+0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; 0x7FFF+0x0001 -> 0x8000, ovf=1.
//  - sub: 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0; 0x8000-0x0001 -> 0x7FFF, ovf=1.
//  - Backpressure: res_ready=0 for 10 cycles -> res_valid, sum stable; start_valid held meanwhile
//    not accepted until the edge after res_ready=1.
//  - rst_n low for 1 cycle during RUN (idx=2) -> all outputs to reset values immediately,
//    start_ready=1; next request completes correctly.

Source files
------------

// File: rtl/mp_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mp_add_sequencer_pkg
// Shared definitions for the multi-precision add/subtract sequencer:
//   - default slice geometry (slice width, slice count)
//   - helpers that derive the total operand width and the slice-index width
//   - the sequencer state encoding (IDLE / RUN / DONE)
// ---------------------------------------------------------------------------
package mp_add_sequencer_pkg;

  localparam int DEF_SLICE_W    = 4;
  localparam int DEF_NUM_SLICES = 4;

  // Full operand width built from the slice geometry.
  function automatic int total_width(input int slice_w, input int num_slices);
    return slice_w * num_slices;
  endfunction

  // Slice index width; a single-slice build still needs a 1-bit index.
  function automatic int idx_width(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mp_add_sequencer_add_slice.sv
// ---------------------------------------------------------------------------
// add_slice
// Purely combinational SLICE_W-bit ripple-carry adder. This is the one shared
// adder that the sequencer time-multiplexes across operand slices.
// Ports:
//   a, b  in   SLICE_W  addend slices
//   ci    in   1        carry in
//   s     out  SLICE_W  sum slice
//   co    out  1        carry out of the slice MSB
// ---------------------------------------------------------------------------
module add_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  always_comb begin
    logic c;
    // NOTE: every output of a combinational block gets a default before any
    // conditional or partial assignment, otherwise synthesis infers a latch.
    s = '0;
    c = ci;
    // The carry ripples through a block-local variable, so blocking
    // assignments here model the chain bit by bit.
    for (int i = 0; i < SLICE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/mp_add_sequencer.sv
// ---------------------------------------------------------------------------
// mp_add_sequencer
// Multi-precision add/subtract built around one shared SLICE_W-bit adder.
// Operands are processed LSB slice first, one slice per clock, with the carry
// registered between slices. Result is held until the consumer takes it.
// Ports:
//   clk          in   1        clock, all state on rising edge
//   rst_n        in   1        asynchronous active-low reset
//   start_valid  in   1        request present with op_a/op_b/cin/sub
//   start_ready  out  1        sequencer idle, request will be accepted
//   op_a, op_b   in   TOTAL_W  operands
//   cin          in   1        carry in for add (ignored for subtract)
//   sub          in   1        1: A-B (B inverted, carry in forced to 1)
//   res_valid    out  1        result valid and held
//   res_ready    in   1        consumer takes the result
//   sum          out  TOTAL_W  result modulo 2^TOTAL_W
//   cout         out  1        carry out of MSB slice (subtract: 1 = no borrow)
//   ovf          out  1        two's-complement signed overflow
//   busy         out  1        slices being processed
// ---------------------------------------------------------------------------
module mp_add_sequencer
  import mp_add_sequencer_pkg::*;
#(
  parameter int SLICE_W    = DEF_SLICE_W,
  parameter int NUM_SLICES = DEF_NUM_SLICES,
  localparam int TOTAL_W   = total_width(SLICE_W, NUM_SLICES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [TOTAL_W-1:0] op_a,
  input  logic [TOTAL_W-1:0] op_b,
  input  logic               cin,
  input  logic               sub,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [TOTAL_W-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic               busy
);

  localparam int IDX_W = idx_width(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_t             state_q;
  logic [TOTAL_W-1:0] a_q;
  logic [TOTAL_W-1:0] b_q;       // already conditionally inverted for subtract
  logic [TOTAL_W-1:0] sum_q;
  logic               carry_q;
  logic               cout_q;
  logic               ovf_q;
  logic [IDX_W-1:0]   idx_q;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] s_sl;
  logic               co_sl;
  logic               last_slice;

  assign last_slice = (idx_q == LAST_IDX);

  // Select the current operand slice with constant part-selects only.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  add_slice #(
    .SLICE_W (SLICE_W)
  ) u_add_slice (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry_q),
    .s  (s_sl),
    .co (co_sl)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // The operand registers are a handful of flops, not a memory array, so
      // they are reset along with the rest to keep the datapath deterministic.
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q     <= op_a;
            b_q     <= op_b ^ {TOTAL_W{sub}};
            carry_q <= sub | cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q <= co_sl;
          for (int i = 0; i < NUM_SLICES; i++) begin
            if (idx_q == IDX_W'(i)) sum_q[i*SLICE_W +: SLICE_W] <= s_sl;
          end
          if (last_slice) begin
            // Signed overflow: operands agree in sign, result sign differs.
            // The result MSB is the MSB of the slice being written this edge.
            cout_q  <= co_sl;
            ovf_q   <= (a_q[TOTAL_W-1] == b_q[TOTAL_W-1]) &&
                       (s_sl[SLICE_W-1] != a_q[TOTAL_W-1]);
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign res_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mp_add_sequencer
// Self-checking bench for mp_add_sequencer (16-bit default build).
// ---------------------------------------------------------------------------
module tb_mp_add_sequencer;

  localparam int SLICE_W    = 4;
  localparam int NUM_SLICES = 4;
  localparam int TOTAL_W    = SLICE_W * NUM_SLICES;
  localparam int MAX_WAIT   = 50;

  typedef struct {
    logic [TOTAL_W-1:0] sum;
    logic               cout;
    logic               ovf;
  } exp_t;

  typedef struct {
    logic [TOTAL_W-1:0] a;
    logic [TOTAL_W-1:0] b;
    logic               cin;
    logic               sub;
    logic [TOTAL_W-1:0] exp_sum;
    logic               exp_cout;
    logic               exp_ovf;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start_valid;
  logic               start_ready;
  logic [TOTAL_W-1:0] op_a;
  logic [TOTAL_W-1:0] op_b;
  logic               cin;
  logic               sub;
  logic               res_valid;
  logic               res_ready;
  logic [TOTAL_W-1:0] sum;
  logic               cout;
  logic               ovf;
  logic               busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mp_add_sequencer #(
    .SLICE_W    (SLICE_W),
    .NUM_SLICES (NUM_SLICES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic done on signed/unsigned integers, not on slices.
  function automatic exp_t model(input logic [TOTAL_W-1:0] a, input logic [TOTAL_W-1:0] b,
                                 input logic ci, input logic sb_);
    exp_t e;
    int   sa, sbv, r;
    int   ua, ub, ur;
    sa = int'($signed(a));
    sbv = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    if (sb_) begin
      r      = sa - sbv;
      ur     = ua - ub;
      e.cout = (ua >= ub);
    end else begin
      r      = sa + sbv + int'(ci);
      ur     = ua + ub + int'(ci);
      e.cout = (ur > 65535);
    end
    e.sum = ur[TOTAL_W-1:0];
    e.ovf = (r > 32767) || (r < -32768);
    return e;
  endfunction

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: result with no expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " sum"},  32'(sum),  32'(e.sum));
      check({tag, " cout"}, 32'(cout), 32'(e.cout));
      check({tag, " ovf"},  32'(ovf),  32'(e.ovf));
    end
  endtask

  // Wait (bounded) for res_valid after an accept edge; returns edge count.
  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [TOTAL_W-1:0] a, input logic [TOTAL_W-1:0] b,
                       input logic ci, input logic sb_, input exp_t e, input string tag);
    int n;
    @(negedge clk);
    check({tag, " start_ready idle"}, 32'(start_ready), 32'd1);
    op_a = a; op_b = b; cin = ci; sub = sb_;
    start_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start_valid = 1'b0;
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    wait_result(n);
    check({tag, " latency"}, 32'(n), 32'(NUM_SLICES));
    compare_result(tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, " res_valid cleared"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    exp_t e, e1, e2;
    int   n;

    vecs[0] = '{16'h0002, 16'h0001, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("reset start_ready", 32'(start_ready), 32'd1);
    check("reset res_valid",   32'(res_valid),   32'd0);
    check("reset busy",        32'(busy),        32'd0);
    check("reset sum",         32'(sum),         32'd0);
    check("reset cout",        32'(cout),        32'd0);
    check("reset ovf",         32'(ovf),         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      e.sum = vecs[i].exp_sum; e.cout = vecs[i].exp_cout; e.ovf = vecs[i].exp_ovf;
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e, $sformatf("vec%0d", i));
    end

    // Random operations against the integer model.
    for (int i = 0; i < 10; i++) begin
      logic [TOTAL_W-1:0] ra, rb;
      logic               rc, rs;
      ra = TOTAL_W'($urandom); rb = TOTAL_W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      do_op(ra, rb, rc, rs, model(ra, rb, rc, rs), $sformatf("rnd%0d", i));
    end

    // Backpressure: result held for 10 cycles while a new request waits.
    e1 = model(16'h1234, 16'h0F0F, 1'b0, 1'b0);
    e2 = model(16'h00FF, 16'h0100, 1'b0, 1'b1);
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0F0F; cin = 1'b0; sub = 1'b0;
    start_valid = 1'b1;
    sb.push_back(e1);
    @(posedge clk); #1;
    op_a = 16'h00FF; op_b = 16'h0100; cin = 1'b0; sub = 1'b1;
    wait_result(n);
    check("bp latency", 32'(n), 32'(NUM_SLICES));
    compare_result("bp first");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d res_valid", k), 32'(res_valid), 32'd1);
      check($sformatf("bp hold%0d sum", k), 32'(sum), 32'(e1.sum));
      check($sformatf("bp hold%0d start_ready", k), 32'(start_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp release res_valid", 32'(res_valid), 32'd0);
    check("bp release start_ready", 32'(start_ready), 32'd1);
    check("bp release busy", 32'(busy), 32'd0);
    check("bp release sum kept", 32'(sum), 32'(e1.sum));
    sb.push_back(e2);
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("bp second accepted", 32'(busy), 32'd1);
    wait_result(n);
    check("bp second latency", 32'(n), 32'(NUM_SLICES));
    compare_result("bp second");
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset in the middle of RUN (slice index 2): result discarded.
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h1111; cin = 1'b0; sub = 1'b0;
    start_valid = 1'b1;
    sb.push_back(model(16'h1111, 16'h1111, 1'b0, 1'b0));
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun partial sum", 32'(sum), 32'h0022);
    check("midrun busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrun rst start_ready", 32'(start_ready), 32'd1);
    check("midrun rst busy",        32'(busy),        32'd0);
    check("midrun rst res_valid",   32'(res_valid),   32'd0);
    check("midrun rst sum",         32'(sum),         32'd0);
    check("midrun rst cout",        32'(cout),        32'd0);
    check("midrun rst ovf",         32'(ovf),         32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'hABCD, 16'h1234, 1'b1, 1'b0, model(16'hABCD, 16'h1234, 1'b1, 1'b0), "post_reset");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
